rambus_sram: RTL and testbench



---
 rtl/rambus_sram.sv | 133 +++++++++++++
 tb/tb_rambus_sram.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rambus_sram.sv
// Word-organised data RAM on the processor rambus: window decode, byte-strobed
// writes, combinational reads, post-reset zero-fill, fault capture and access counters.
module rambus_sram #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          CNT_W       = 32,
  parameter bit          INIT_ZERO   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      bus_addr,
  input  logic             bus_re,
  input  logic             bus_we,
  input  logic [3:0]       bus_wstrb,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             init_busy,
  output logic             fault,
  output logic [31:0]      fault_addr,
  input  logic             clear_fault,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) << 2;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_ptr;
  logic [31:0]       r_mem [DEPTH_WORDS];
  logic              r_fault;
  logic [31:0]       r_fault_addr;
  logic [CNT_W-1:0]  r_rd_count;
  logic [CNT_W-1:0]  r_wr_count;

  logic [32:0]       w_off;
  logic              w_in_range;
  logic [AW-1:0]     w_idx;
  logic              w_init;
  logic              w_run;
  logic              w_rd_hit;
  logic              w_wr_hit;
  logic              w_access;
  logic              w_oob;
  logic              w_unused;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // 33-bit offset: bit 32 set means the address lies below the window.
  assign w_off      = {1'b0, bus_addr} - {1'b0, BASE_ADDR};
  assign w_in_range = !w_off[32] && (w_off < WIN_BYTES);
  assign w_idx      = w_off[AW+1:2];
  assign w_unused   = &{1'b0, w_off};

  always_ff @(posedge clk) begin
    if (rst) r_state <= INIT_ZERO ? ST_INIT : ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init      = 1'b0;
    w_run       = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init = 1'b1;
        if (r_ptr == AW'(DEPTH_WORDS - 1)) w_state_nxt = ST_RUN;
      end
      ST_RUN:  w_run = 1'b1;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign w_rd_hit = w_run && bus_re && w_in_range;
  assign w_wr_hit = w_run && bus_we && w_in_range && (bus_wstrb != 4'b0000);
  assign w_access = bus_re || (bus_we && (bus_wstrb != 4'b0000));
  assign w_oob    = w_run && w_access && !w_in_range;

  assign bus_rdata  = w_rd_hit ? r_mem[w_idx] : 32'h0;
  assign init_busy  = w_init;
  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;
  assign rd_count   = r_rd_count;
  assign wr_count   = r_wr_count;

  always_ff @(posedge clk) begin
    if (rst)         r_ptr <= '0;
    else if (w_init) r_ptr <= r_ptr + AW'(1);
  end

  // Memory has no reset; the sweep and bus writes are the only writers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_init) begin
        r_mem[r_ptr] <= 32'h0;
      end else if (w_wr_hit) begin
        for (int i = 0; i < 4; i++) begin
          if (bus_wstrb[i]) r_mem[w_idx][8*i +: 8] <= bus_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_rd_hit) r_rd_count <= sat_inc(r_rd_count);
      if (w_wr_hit) r_wr_count <= sat_inc(r_wr_count);
    end
  end

  // A new fault beats a simultaneous clear; otherwise the first capture sticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault      <= 1'b0;
      r_fault_addr <= 32'h0;
    end else if (w_oob && (!r_fault || clear_fault)) begin
      r_fault      <= 1'b1;
      r_fault_addr <= bus_addr;
    end else if (clear_fault) begin
      r_fault      <= 1'b0;
      r_fault_addr <= 32'h0;
    end
  end

endmodule

// File: tb/tb_rambus_sram.sv
// Bench for rambus_sram: directed scenarios plus a randomized run, all checked
// against a word-array reference model of the RAM, counters and fault capture.
module tb_rambus_sram;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 16;
  localparam int          CW    = 4;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   bus_addr = '0;
  logic          bus_re = 1'b0;
  logic          bus_we = 1'b0;
  logic [3:0]    bus_wstrb = '0;
  logic [31:0]   bus_wdata = '0;
  logic          clear_fault = 1'b0;
  logic [31:0]   bus_rdata;
  logic          init_busy;
  logic          fault;
  logic [31:0]   fault_addr;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] wr_count;

  int errors = 0;
  int checks = 0;

  // reference model
  logic [31:0] m_mem [DEPTH];
  int          m_busy_left = DEPTH;
  logic        m_fault = 1'b0;
  logic [31:0] m_faddr = '0;
  int          m_rd = 0;
  int          m_wr = 0;

  rambus_sram #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .CNT_W(CW), .INIT_ZERO(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_re(bus_re), .bus_we(bus_we),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .init_busy(init_busy), .fault(fault), .fault_addr(fault_addr),
    .clear_fault(clear_fault), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // One bus cycle: drive, sample combinational outputs at negedge, clock, update model.
  task automatic step(input logic re, input logic we, input logic [3:0] st,
                      input logic [31:0] a, input logic [31:0] wd, input logic clr,
                      output logic [31:0] rd_obs, output logic [31:0] rd_exp,
                      output logic busy_obs, output logic busy_exp);
    longint off;
    bit     inr;
    int     idx;
    bus_re = re; bus_we = we; bus_wstrb = st; bus_addr = a; bus_wdata = wd;
    clear_fault = clr;
    off = longint'(a) - longint'(BASE);
    inr = (off >= 0) && (off < 4 * DEPTH);
    idx = inr ? int'(off / 4) : 0;
    @(negedge clk);
    rd_obs   = bus_rdata;
    busy_obs = init_busy;
    busy_exp = (m_busy_left > 0);
    rd_exp   = (!busy_exp && re && inr) ? m_mem[idx] : 32'h0;
    @(posedge clk);
    if (rst) begin
      m_busy_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
      m_fault = 1'b0; m_faddr = 32'h0; m_rd = 0; m_wr = 0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
    end else begin
      if (re && inr && m_rd < CMAX) m_rd++;
      if (we && inr && st != 4'b0) begin
        if (m_wr < CMAX) m_wr++;
        for (int i = 0; i < 4; i++)
          if (st[i]) m_mem[idx][8*i +: 8] = wd[8*i +: 8];
      end
      if ((re || (we && st != 4'b0)) && !inr && (!m_fault || clr)) begin
        m_fault = 1'b1; m_faddr = a;
      end else if (clr) begin
        m_fault = 1'b0; m_faddr = 32'h0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    logic [31:0] ro, rx;
    logic bo, bx;
    int g;
    rst = 1'b1;
    step(0, 0, 4'h0, 32'h0, 32'h0, 0, ro, rx, bo, bx);
    rst = 1'b0;
    g = 0;
    while (init_busy === 1'b1 && g < 100) begin
      step(0, 0, 4'h0, 32'h0, 32'h0, 0, ro, rx, bo, bx);
      g++;
    end
    checks++;
    if (g >= 100 || init_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_sweep_bound: init_busy=%b after %0d cycles, required 0", init_busy, g);
    end
  endtask

  task automatic test_reset();
    logic [31:0] ro, rx;
    logic bo, bx;
    int nb, g;
    rst = 1'b1;
    step(0, 0, 4'h0, 32'h0, 32'h0, 0, ro, rx, bo, bx);
    step(0, 0, 4'h0, 32'h0, 32'h0, 0, ro, rx, bo, bx);
    rst = 1'b0;
    checks++;
    if ({init_busy, fault, fault_addr, rd_count, wr_count} !== {1'b1, 1'b0, 32'h0, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset_state: busy=%b fault=%b faddr=%h rd=%h wr=%h, required 1 0 0 0 0",
               init_busy, fault, fault_addr, rd_count, wr_count);
    end
    nb = 0;
    step(0, 1, 4'hF, BASE, 32'hA5A5_A5A5, 0, ro, rx, bo, bx);
    nb += int'(bo);
    step(1, 0, 4'h0, BASE, 32'h0, 0, ro, rx, bo, bx);
    nb += int'(bo);
    checks++;
    if (ro !== 32'h0) begin
      errors++;
      $display("FAIL init_read_zero: rdata=%h, required 00000000", ro);
    end
    g = 0;
    while (init_busy === 1'b1 && g < 100) begin
      step(0, 0, 4'h0, 32'h0, 32'h0, 0, ro, rx, bo, bx);
      nb += int'(bo);
      g++;
    end
    checks++;
    if (nb !== DEPTH) begin
      errors++;
      $display("FAIL init_busy_len: busy cycles=%0d, required %0d", nb, DEPTH);
    end
    step(1, 0, 4'h0, BASE, 32'h0, 0, ro, rx, bo, bx);
    checks++;
    if (ro !== 32'h0) begin
      errors++;
      $display("FAIL post_init_read: rdata=%h, required 00000000", ro);
    end
    checks++;
    if (rd_count !== 4'd1 || wr_count !== 4'd0) begin
      errors++;
      $display("FAIL init_counts: rd=%0d wr=%0d, required rd=1 wr=0", rd_count, wr_count);
    end
  endtask

  task automatic test_write_strobe();
    logic [31:0] ro, rx;
    logic bo, bx;
    do_reset();
    step(0, 1, 4'hF, BASE + 32'd8, 32'hDEAD_BEEF, 0, ro, rx, bo, bx);
    step(1, 0, 4'h0, BASE + 32'd8, 32'h0, 0, ro, rx, bo, bx);
    checks++;
    if (ro !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL full_write: rdata=%h, required deadbeef", ro);
    end
    step(0, 1, 4'b0010, BASE + 32'd8, 32'h0000_5500, 0, ro, rx, bo, bx);
    step(1, 0, 4'h0, BASE + 32'd8, 32'h0, 0, ro, rx, bo, bx);
    checks++;
    if (ro !== 32'hDEAD_55EF) begin
      errors++;
      $display("FAIL lane_write: rdata=%h, required dead55ef", ro);
    end
    step(0, 1, 4'b0000, BASE + 32'd8, 32'hFFFF_FFFF, 0, ro, rx, bo, bx);
    checks++;
    if (wr_count !== 4'd2 || rd_count !== 4'd2) begin
      errors++;
      $display("FAIL strobe_counts: rd=%0d wr=%0d, required rd=2 wr=2", rd_count, wr_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ro, rx;
    logic bo, bx;
    step(0, 1, 4'hF, BASE + 32'd4, 32'h1111_1111, 0, ro, rx, bo, bx);
    step(1, 1, 4'hF, BASE + 32'd4, 32'h2222_2222, 0, ro, rx, bo, bx);
    checks++;
    if (ro !== 32'h1111_1111) begin
      errors++;
      $display("FAIL rw_same_cycle: rdata=%h, required 11111111", ro);
    end
    step(1, 0, 4'h0, BASE + 32'd4, 32'h0, 0, ro, rx, bo, bx);
    checks++;
    if (ro !== 32'h2222_2222) begin
      errors++;
      $display("FAIL rw_next_cycle: rdata=%h, required 22222222", ro);
    end
  endtask

  // Entered with rd=4, wr=4, word2=dead55ef, word15=0, no fault.
  task automatic test_fault();
    logic [31:0] ro, rx;
    logic bo, bx;
    step(1, 0, 4'h0, BASE + 32'd64, 32'h0, 0, ro, rx, bo, bx);
    checks++;
    if (ro !== 32'h0 || fault !== 1'b1 || fault_addr !== BASE + 32'd64) begin
      errors++;
      $display("FAIL fault_capture: rdata=%h fault=%b faddr=%h, required 0 1 %h", ro, fault, fault_addr, BASE + 32'd64);
    end
    step(0, 1, 4'hF, BASE - 32'd4, 32'hBAD0_BAD0, 0, ro, rx, bo, bx);
    checks++;
    if (fault !== 1'b1 || fault_addr !== BASE + 32'd64) begin
      errors++;
      $display("FAIL fault_sticky: fault=%b faddr=%h, required 1 %h", fault, fault_addr, BASE + 32'd64);
    end
    checks++;
    if (rd_count !== 4'd4 || wr_count !== 4'd4) begin
      errors++;
      $display("FAIL fault_nocount: rd=%0d wr=%0d, required rd=4 wr=4", rd_count, wr_count);
    end
    step(1, 0, 4'h0, BASE + 32'd60, 32'h0, 0, ro, rx, bo, bx);
    checks++;
    if (ro !== 32'h0) begin
      errors++;
      $display("FAIL fault_nowrite_last: rdata=%h, required 00000000", ro);
    end
    step(1, 0, 4'h0, BASE + 32'd8, 32'h0, 0, ro, rx, bo, bx);
    checks++;
    if (ro !== 32'hDEAD_55EF) begin
      errors++;
      $display("FAIL fault_mem_intact: rdata=%h, required dead55ef", ro);
    end
  endtask

  task automatic test_clear_fault();
    logic [31:0] ro, rx;
    logic bo, bx;
    step(1, 0, 4'h0, 32'hFFFF_FFFC, 32'h0, 1, ro, rx, bo, bx);
    checks++;
    if (fault !== 1'b1 || fault_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL clear_vs_new: fault=%b faddr=%h, required 1 fffffffc", fault, fault_addr);
    end
    step(0, 0, 4'h0, 32'h0, 32'h0, 1, ro, rx, bo, bx);
    checks++;
    if (fault !== 1'b0 || fault_addr !== 32'h0) begin
      errors++;
      $display("FAIL clear_alone: fault=%b faddr=%h, required 0 00000000", fault, fault_addr);
    end
  endtask

  task automatic test_saturate();
    logic [31:0] ro, rx;
    logic bo, bx;
    logic [31:0] a;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
      step(1, 0, 4'h0, a, 32'h0, 0, ro, rx, bo, bx);
    end
    checks++;
    if (rd_count !== 4'hF) begin
      errors++;
      $display("FAIL rd_saturate: rd=%h, required f", rd_count);
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [31:0] ro, rx;
    logic bo, bx;
    int nb, g;
    rst = 1'b1;
    step(0, 0, 4'h0, 32'h0, 32'h0, 0, ro, rx, bo, bx);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) step(0, 0, 4'h0, 32'h0, 32'h0, 0, ro, rx, bo, bx);
    rst = 1'b1;
    step(0, 0, 4'h0, 32'h0, 32'h0, 0, ro, rx, bo, bx);
    rst = 1'b0;
    checks++;
    if (rd_count !== 4'h0 || wr_count !== 4'h0 || init_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_state: rd=%h wr=%h busy=%b, required 0 0 1", rd_count, wr_count, init_busy);
    end
    nb = 0;
    g  = 0;
    while (init_busy === 1'b1 && g < 100) begin
      step(0, 0, 4'h0, 32'h0, 32'h0, 0, ro, rx, bo, bx);
      nb += int'(bo);
      g++;
    end
    checks++;
    if (nb !== DEPTH) begin
      errors++;
      $display("FAIL mid_reset_sweep: busy cycles=%0d, required %0d", nb, DEPTH);
    end
  endtask

  task automatic test_random();
    logic [31:0] ro, rx, a;
    logic bo, bx;
    logic re, we, clr;
    logic [3:0] st;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 7))
        0:       a = BASE - 32'($urandom_range(1, 8));
        1:       a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 8));
        2:       a = $urandom;
        default: a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
      endcase
      re  = 1'($urandom);
      we  = 1'($urandom);
      st  = 4'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      step(re, we, st, a, $urandom, clr, ro, rx, bo, bx);
      checks++;
      if (ro !== rx || bo !== bx) begin
        errors++;
        $display("FAIL rand_read[%0d]: rdata=%h busy=%b, required %h %b", k, ro, bo, rx, bx);
      end
      checks++;
      if (fault !== m_fault || fault_addr !== m_faddr ||
          rd_count !== CW'(m_rd) || wr_count !== CW'(m_wr)) begin
        errors++;
        $display("FAIL rand_state[%0d]: fault=%b faddr=%h rd=%0d wr=%0d, required %b %h %0d %0d",
                 k, fault, fault_addr, rd_count, wr_count, m_fault, m_faddr, m_rd, m_wr);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    test_reset();
    test_write_strobe();
    test_back_to_back();
    test_fault();
    test_clear_fault();
    test_saturate();
    test_reset_mid_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
